// File: rtl/read_db_agent.sv
// Read data buffer agent: pre-allocates entries to read requests, captures SRAM
// return data, and drains filled entries upstream in fill order.
module read_db_agent #(
    parameter int ENTRY_NUM   = 16,
    parameter int DATA_WIDTH  = 1024,
    parameter int TXNID_WIDTH = 16,
    localparam int ID_W       = $clog2(ENTRY_NUM)
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   alloc_vld,
    output logic [ID_W-1:0]        alloc_idx,
    input  logic                   alloc_rdy,
    input  logic                   sram_rd_vld,
    input  logic [ID_W-1:0]        sram_rd_entry_id,
    input  logic [TXNID_WIDTH-1:0] sram_rd_txnid,
    input  logic [DATA_WIDTH-1:0]  sram_rd_data,
    output logic                   resp_vld,
    input  logic                   resp_rdy,
    output logic [ID_W-1:0]        resp_entry_id,
    output logic [TXNID_WIDTH-1:0] resp_txnid,
    output logic [DATA_WIDTH-1:0]  resp_data,
    output logic                   fill_err,
    output logic [ID_W:0]          free_cnt
);

    // state    | meaning
    // ST_FREE  | unowned, may be offered for allocation
    // ST_ALLOC | owned by a request, waiting for SRAM data
    // ST_FULL  | data captured, queued in the fill-order FIFO
    // ST_DRAIN | data moved to the output stage, awaiting response handshake
    localparam logic [1:0] ST_FREE  = 2'd0;
    localparam logic [1:0] ST_ALLOC = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    logic [1:0]                        ent_st [ENTRY_NUM];
    logic [DATA_WIDTH+TXNID_WIDTH-1:0] store  [ENTRY_NUM];
    logic [ID_W-1:0]                   ofifo  [ENTRY_NUM];
    logic [ID_W:0]                     wr_ptr;
    logic [ID_W:0]                     rd_ptr;
    logic [ID_W-1:0]                   fifo_head;
    logic                              fifo_empty;
    logic                              fifo_full;
    logic                              fill_ok;
    logic                              alloc_fire;
    logic                              resp_fire;
    logic                              pop;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[ID_W] != rd_ptr[ID_W]) &&
                        (wr_ptr[ID_W-1:0] == rd_ptr[ID_W-1:0]);
    assign fifo_head  = ofifo[rd_ptr[ID_W-1:0]];

    assign fill_ok    = sram_rd_vld && (ent_st[sram_rd_entry_id] == ST_ALLOC);
    assign alloc_fire = alloc_vld && alloc_rdy;
    assign resp_fire  = resp_vld && resp_rdy;
    assign pop        = !fifo_empty && (!resp_vld || resp_rdy);

    // Lowest free index wins; scanning downward leaves the lowest one last.
    always_comb begin
        alloc_vld = 1'b0;
        alloc_idx = '0;
        free_cnt  = '0;
        for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
            if (ent_st[i] == ST_FREE) begin
                alloc_vld = 1'b1;
                alloc_idx = ID_W'(i);
                free_cnt  = free_cnt + (ID_W + 1)'(1);
            end
        end
    end

    // The four transitions always target entries in distinct states, so at
    // most one of them can hit a given entry in a cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRY_NUM; i++) ent_st[i] <= ST_FREE;
        end else begin
            for (int i = 0; i < ENTRY_NUM; i++) begin
                if (alloc_fire && alloc_idx == ID_W'(i))
                    ent_st[i] <= ST_ALLOC;
                else if (fill_ok && sram_rd_entry_id == ID_W'(i))
                    ent_st[i] <= ST_FULL;
                else if (pop && fifo_head == ID_W'(i))
                    ent_st[i] <= ST_DRAIN;
                else if (resp_fire && resp_entry_id == ID_W'(i))
                    ent_st[i] <= ST_FREE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (fill_ok) begin
            store[sram_rd_entry_id]    <= {sram_rd_txnid, sram_rd_data};
            ofifo[wr_ptr[ID_W-1:0]]    <= sram_rd_entry_id;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (fill_ok) wr_ptr <= wr_ptr + (ID_W + 1)'(1);
            if (pop)     rd_ptr <= rd_ptr + (ID_W + 1)'(1);
        end
    end

    // Output stage doubles as the storage read register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_vld      <= 1'b0;
            resp_entry_id <= '0;
            resp_txnid    <= '0;
            resp_data     <= '0;
        end else if (pop) begin
            resp_vld                  <= 1'b1;
            resp_entry_id             <= fifo_head;
            {resp_txnid, resp_data}   <= store[fifo_head];
        end else if (resp_fire) begin
            resp_vld <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) fill_err <= 1'b0;
        else     fill_err <= sram_rd_vld && !fill_ok;
    end

    a_no_fifo_overflow: assert property (@(posedge clk) disable iff (rst)
        !(fill_ok && fifo_full && !pop));

endmodule

// File: tb/tb_read_db_agent.sv
// Scoreboard bench for read_db_agent: directed scenarios plus a random soak.
module tb_read_db_agent;
    localparam int N  = 16;
    localparam int DW = 1024;
    localparam int TW = 16;
    localparam int IW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          alloc_vld;
    logic [IW-1:0] alloc_idx;
    logic          alloc_rdy;
    logic          sram_rd_vld;
    logic [IW-1:0] sram_rd_entry_id;
    logic [TW-1:0] sram_rd_txnid;
    logic [DW-1:0] sram_rd_data;
    logic          resp_vld;
    logic          resp_rdy;
    logic [IW-1:0] resp_entry_id;
    logic [TW-1:0] resp_txnid;
    logic [DW-1:0] resp_data;
    logic          fill_err;
    logic [IW:0]   free_cnt;

    read_db_agent #(.ENTRY_NUM(N), .DATA_WIDTH(DW), .TXNID_WIDTH(TW)) dut (
        .clk(clk), .rst(rst),
        .alloc_vld(alloc_vld), .alloc_idx(alloc_idx), .alloc_rdy(alloc_rdy),
        .sram_rd_vld(sram_rd_vld), .sram_rd_entry_id(sram_rd_entry_id),
        .sram_rd_txnid(sram_rd_txnid), .sram_rd_data(sram_rd_data),
        .resp_vld(resp_vld), .resp_rdy(resp_rdy), .resp_entry_id(resp_entry_id),
        .resp_txnid(resp_txnid), .resp_data(resp_data),
        .fill_err(fill_err), .free_cnt(free_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [IW-1:0] id;
        logic [TW-1:0] txn;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          sbq[$];
    int            st[N];        // 0 free, 1 alloc, 2 filled/draining
    int            n_tests = 0;
    int            n_fail  = 0;
    int            n_resp  = 0;
    bit            held_vld = 1'b0;
    logic [IW-1:0] held_id;
    logic [TW-1:0] held_txn;
    logic [DW-1:0] held_data;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every response handshake.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            held_vld = 1'b0;
        end else if (resp_vld) begin
            if (held_vld) begin
                chk("stall_id", resp_entry_id, held_id);
                chk("stall_txnid", resp_txnid, held_txn);
                n_tests++;
                if (resp_data !== held_data) begin
                    n_fail++;
                    $display("FAIL stall_data: got lo %h expected lo %h",
                             resp_data[63:0], held_data[63:0]);
                end
            end
            if (resp_rdy) begin
                held_vld = 1'b0;
                if (sbq.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_resp: got entry %0d expected none", resp_entry_id);
                end else begin
                    e = sbq.pop_front();
                    chk("resp_entry_id", resp_entry_id, e.id);
                    chk("resp_txnid", resp_txnid, e.txn);
                    n_tests++;
                    if (resp_data !== e.data) begin
                        n_fail++;
                        $display("FAIL resp_data entry %0d: got lo %h expected lo %h",
                                 e.id, resp_data[63:0], e.data[63:0]);
                    end
                    st[e.id] = 0;
                    n_resp++;
                end
            end else begin
                held_vld  = 1'b1;
                held_id   = resp_entry_id;
                held_txn  = resp_txnid;
                held_data = resp_data;
            end
        end else begin
            held_vld = 1'b0;
        end
    end

    // One clock cycle: check allocation outputs against the model, drive,
    // advance past the edge, then check the fill error pulse.
    task automatic step(input bit da, input bit df, input int fid,
                        input logic [TW-1:0] txn, input bit rr);
        int   lo;
        int   fc;
        bit   err;
        exp_t e;
        lo = -1;
        fc = 0;
        for (int i = N - 1; i >= 0; i--) begin
            if (st[i] == 0) begin
                lo = i;
                fc++;
            end
        end
        chk("alloc_vld", alloc_vld, (lo >= 0) ? 1 : 0);
        chk("alloc_idx", alloc_idx, (lo >= 0) ? lo : 0);
        chk("free_cnt", free_cnt, fc);
        alloc_rdy        = da;
        resp_rdy         = rr;
        sram_rd_vld      = df;
        sram_rd_entry_id = fid[IW-1:0];
        sram_rd_txnid    = txn;
        for (int k = 0; k < DW / 32; k++) sram_rd_data[k*32 +: 32] = $urandom;
        err = 1'b0;
        if (df) begin
            if (st[fid] == 1) begin
                e.id   = fid[IW-1:0];
                e.txn  = txn;
                e.data = sram_rd_data;
                sbq.push_back(e);
                st[fid] = 2;
            end else begin
                err = 1'b1;
            end
        end
        if (da && lo >= 0) st[lo] = 1;
        @(posedge clk);
        #1;
        alloc_rdy   = 1'b0;
        sram_rd_vld = 1'b0;
        chk("fill_err", fill_err, err);
    endtask

    initial begin
        int base;
        int ord[N];
        int fid;
        bit df;

        rst = 1'b1;
        alloc_rdy = 1'b0;
        sram_rd_vld = 1'b0;
        sram_rd_entry_id = '0;
        sram_rd_txnid = '0;
        sram_rd_data = '0;
        resp_rdy = 1'b0;
        for (int i = 0; i < N; i++) st[i] = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        chk("rst_resp_vld", resp_vld, 0);
        chk("rst_resp_id", resp_entry_id, 0);
        chk("rst_resp_txnid", resp_txnid, 0);
        chk("rst_resp_data_lo", resp_data[63:0], 0);
        chk("rst_fill_err", fill_err, 0);
        chk("rst_free_cnt", free_cnt, 16);
        step(0, 0, 0, 0, 0);

        // Out-of-order fill, latency
        repeat (3) step(1, 0, 0, 0, 1);
        step(0, 1, 2, 16'h0022, 1);
        chk("lat_vld_early", resp_vld, 0);
        step(0, 1, 0, 16'h0000, 1);
        chk("lat_vld_2cyc", resp_vld, 1);
        chk("lat_first_id", resp_entry_id, 2);
        base = n_resp;
        step(0, 1, 1, 16'h0011, 1);
        repeat (3) step(0, 0, 0, 0, 1);
        chk("ooo_resp_cnt", n_resp - base, 3);
        chk("ooo_idle_vld", resp_vld, 0);

        // Fill to a free entry
        base = n_resp;
        step(0, 1, 5, 16'h0055, 1);
        repeat (3) step(0, 0, 0, 0, 1);
        chk("err_no_resp", n_resp - base, 0);

        // Fill all entries, stall, then release with alloc_rdy held
        for (int k = 0; k < N; k++) step(1, 0, 0, 0, 0);
        ord[0] = 0;
        for (int k = 1; k < N; k++) ord[k] = N - k;
        for (int k = 0; k < N; k++) step(0, 1, ord[k], 16'h1000 + 16'(ord[k]), 0);
        repeat (10) step(0, 0, 0, 0, 0);
        chk("stall_vld", resp_vld, 1);
        chk("stall_head", resp_entry_id, 0);
        chk("full_alloc_vld", alloc_vld, 0);
        base = n_resp;
        for (int k = 0; k < N; k++) begin
            chk("b2b_vld", resp_vld, 1);
            step((k == 0) ? 1'b1 : 1'b0, 0, 0, 0, 1);
        end
        chk("b2b_resp_cnt", n_resp - base, 16);
        chk("b2b_done_vld", resp_vld, 0);
        chk("b2b_free_cnt", free_cnt, 16);
        step(0, 0, 0, 0, 1);

        // Reset mid-drain
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(0, 1, 0, 16'h0A0A, 0);
        step(0, 1, 1, 16'h0B0B, 0);
        chk("pre_rst_vld", resp_vld, 1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_vld", resp_vld, 0);
        chk("mid_rst_free_cnt", free_cnt, 16);
        sbq.delete();
        for (int i = 0; i < N; i++) st[i] = 0;
        @(posedge clk);
        #1 rst = 1'b0;
        base = n_resp;
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        chk("post_rst_no_resp", n_resp - base, 0);

        // Random soak
        for (int c = 0; c < 10000; c++) begin
            base = $urandom_range(0, N - 1);
            df = 1'b0;
            fid = 0;
            for (int j = 0; j < N; j++) begin
                if (!df && st[(base + j) % N] == 1) begin
                    df = 1'b1;
                    fid = (base + j) % N;
                end
            end
            if ($urandom_range(0, 3) == 0) df = 1'b0;
            step($urandom_range(0, 1) == 1, df, fid, 16'($urandom),
                 $urandom_range(0, 3) != 0);
        end
        for (int c = 0; c < 200 && sbq.size() > 0; c++) step(0, 0, 0, 0, 1);
        chk("soak_drained", sbq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
